// File: rtl/data_memory_hs.sv
// data_memory_hs: handshaked byte-addressed data memory with wait states and fault reporting
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_valid/o_req_ready   request handshake (ready only in IDLE)
//   i_req_write               1 = store, 0 = load
//   i_req_size                0 byte, 1 half, 2 word, 3 illegal
//   i_req_unsigned            load extension: 1 zero, 0 sign
//   i_req_addr, i_req_wdata   little-endian byte address, store data
//   o_resp_valid              one-cycle completion pulse
//   o_resp_rdata, o_resp_fault extended load data / rejected access
// Config macro: DMEM_ALIGN_CHECK_EN (misaligned half/word accesses fault instead of being forced aligned)
module data_memory_hs #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_fault
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_write, r_unsigned;
  logic [1:0] r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0][7:0] r_mem [DEPTH];
  logic w_accept, w_enter, w_fault, w_write, w_unsigned;
  logic [1:0] w_size, w_lane;
  logic [ADDR_W-1:0] w_addr;
  logic [IW-1:0] w_idx;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_wrep, w_word, w_shift, w_load;
  assign o_req_ready  = r_state == IDLE;
  assign o_resp_valid = r_state == RESP;
  assign w_accept     = i_req_valid & o_req_ready;
  assign w_enter      = (w_next == RESP) && (r_state != RESP);
  // With zero latency the RESP entry coincides with acceptance, so use the live request then.
  assign w_write    = o_req_ready ? i_req_write    : r_write;
  assign w_unsigned = o_req_ready ? i_req_unsigned : r_unsigned;
  assign w_size     = o_req_ready ? i_req_size     : r_size;
  assign w_addr     = o_req_ready ? i_req_addr     : r_addr;
  assign w_wdata    = o_req_ready ? i_req_wdata    : r_wdata;
  assign w_idx      = w_addr[IW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = (w_size == 2'd1 && w_addr[0]) || (w_size == 2'd2 && w_addr[1:0] != 2'd0);
  assign w_lane     = w_addr[1:0];
  assign w_fault    = w_size == 2'd3 || (w_addr >> (IW + 2)) != '0 || w_misalign;
`else
  // Misaligned half/word accesses are silently forced onto their natural boundary.
  assign w_lane  = w_size == 2'd2 ? 2'd0 : w_size == 2'd1 ? {w_addr[1], 1'b0} : w_addr[1:0];
  assign w_fault = w_size == 2'd3 || (w_addr >> (IW + 2)) != '0;
`endif
  assign w_be    = w_size == 2'd0 ? 4'b0001 << w_lane : w_size == 2'd1 ? (w_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wrep  = w_size == 2'd0 ? {4{w_wdata[7:0]}} : w_size == 2'd1 ? {2{w_wdata[15:0]}} : w_wdata;
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_load  = w_size == 2'd0 ? {{24{~w_unsigned & w_shift[7]}}, w_shift[7:0]}
                 : w_size == 2'd1 ? {{16{~w_unsigned & w_shift[15]}}, w_shift[15:0]} : w_word;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE;
    else if (r_state == WAIT) w_next = r_cnt == 4'd0 ? RESP : WAIT;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      o_resp_rdata <= 32'd0;
      o_resp_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write    <= i_req_write;
        r_unsigned <= i_req_unsigned;
        r_size     <= i_req_size;
        r_addr     <= i_req_addr;
        r_wdata    <= i_req_wdata;
        r_cnt      <= 4'(LATENCY > 0 ? LATENCY - 1 : 0);
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter) begin
        o_resp_rdata <= (w_write || w_fault) ? 32'd0 : w_load;
        o_resp_fault <= w_fault;
      end
    end
  end
  // Reset gates the commit so an access aborted on the RESP-entry edge leaves memory untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_enter && w_write && !w_fault)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][i] <= w_wrep[8*i+:8];
  end
endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: directed bench for data_memory_hs at LATENCY 0, 3 and 2
module tb_data_memory_hs;
  logic clk = 1'b0;
  logic rst_n [3];
  logic valid [3], ready [3], write [3], uns [3], rvalid [3], fault [3];
  logic [1:0] size [3];
  logic [31:0] addr [3], wdata [3], rdata [3];
  int lat_of [3] = '{0, 3, 2};
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gi
    data_memory_hs #(.DEPTH(128), .ADDR_W(32), .LATENCY(g == 0 ? 0 : g == 1 ? 3 : 2)) u (
      .i_clk(clk), .i_rst_n(rst_n[g]), .i_req_valid(valid[g]), .o_req_ready(ready[g]),
      .i_req_write(write[g]), .i_req_size(size[g]), .i_req_unsigned(uns[g]),
      .i_req_addr(addr[g]), .i_req_wdata(wdata[g]), .o_resp_valid(rvalid[g]),
      .o_resp_rdata(rdata[g]), .o_resp_fault(fault[g]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input int k, input logic w, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic f, output int lat);
    int n;
    @(negedge clk);
    valid[k] = 1'b1; write[k] = w; size[k] = sz; uns[k] = un; addr[k] = a; wdata[k] = d;
    n = 0;
    while (!ready[k] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 valid[k] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid[k] && lat < 50);
    rd = rdata[k];
    f = fault[k];
    @(negedge clk);
    chk("pulse_width", {31'b0, rvalid[k]}, 32'd0);
  endtask
  task automatic op(input string tag, input int k, input logic w, input logic [1:0] sz, input logic un,
                    input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_f);
    logic [31:0] rd;
    logic f;
    int lat;
    xfer(k, w, sz, un, a, d, rd, f, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_fault"}, {31'b0, f}, {31'b0, exp_f});
    chk({tag, "_latency"}, lat, lat_of[k] + 1);
  endtask
  initial begin
    int lat;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; valid[k] = 1'b0; write[k] = 1'b0; size[k] = 2'd0;
      uns[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", {31'b0, ready[k]}, 32'd1);
      chk("rst_valid", {31'b0, rvalid[k]}, 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_fault", {31'b0, fault[k]}, 32'd0);
    end
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    op("st10", 0, 1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    op("ld10", 0, 0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    op("st20", 0, 1, 2, 0, 32'h20, 32'h0, 32'h0, 0);
    op("stb21", 0, 1, 0, 0, 32'h21, 32'h80, 32'h0, 0);
    op("sth22", 0, 1, 1, 0, 32'h22, 32'h1234, 32'h0, 0);
    op("ldw20", 0, 0, 2, 0, 32'h20, 32'h0, 32'h12348000, 0);
    op("ldbs21", 0, 0, 0, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0);
    op("ldbu21", 0, 0, 0, 1, 32'h21, 32'h0, 32'h00000080, 0);
    op("ldhs22", 0, 0, 1, 0, 32'h22, 32'h0, 32'h00001234, 0);
    op("ldhs20", 0, 0, 1, 0, 32'h20, 32'h0, 32'hFFFF8000, 0);
    op("ldhu20", 0, 0, 1, 1, 32'h20, 32'h0, 32'h00008000, 0);
    op("st00", 0, 1, 2, 0, 32'h0, 32'h0, 32'h0, 0);
    op("st200", 0, 1, 2, 0, 32'h200, 32'h11111111, 32'h0, 1);
    op("ld00", 0, 0, 2, 0, 32'h0, 32'h0, 32'h0, 0);
    op("size3", 0, 0, 3, 0, 32'h10, 32'h0, 32'h0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
    op("ldw12", 0, 0, 2, 0, 32'h12, 32'h0, 32'h0, 1);
    op("ldh23", 0, 0, 1, 0, 32'h23, 32'h0, 32'h0, 1);
`else
    op("ldw12", 0, 0, 2, 0, 32'h12, 32'h0, 32'hDEADBEEF, 0);
    op("ldh23", 0, 0, 1, 0, 32'h23, 32'h0, 32'h00001234, 0);
`endif
    op("l3_st04", 1, 1, 2, 0, 32'h4, 32'h55, 32'h0, 0);
    @(negedge clk);
    valid[1] = 1'b1; write[1] = 1'b0; size[1] = 2'd2; uns[1] = 1'b0; addr[1] = 32'h4;
    chk("l3_c10_ready", {31'b0, ready[1]}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("l3_busy_ready", {31'b0, ready[1]}, 32'd0);
      chk("l3_resp_valid", {31'b0, rvalid[1]}, {31'b0, i == 4});
    end
    chk("l3_c14_rdata", rdata[1], 32'h55);
    @(negedge clk);
    chk("l3_c15_ready", {31'b0, ready[1]}, 32'd1);
    @(posedge clk);
    #1 valid[1] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid[1] && lat < 50);
    chk("l3_held_latency", lat, 32'd4);
    chk("l3_held_rdata", rdata[1], 32'h55);
    op("l2_st40", 2, 1, 2, 0, 32'h40, 32'h0, 32'h0, 0);
    @(negedge clk);
    valid[2] = 1'b1; write[2] = 1'b1; size[2] = 2'd2; addr[2] = 32'h40; wdata[2] = 32'hCAFEF00D;
    @(posedge clk);
    #1 valid[2] = 1'b0;
    rst_n[2] = 1'b0;
    @(posedge clk);
    #1 rst_n[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'b0, rvalid[2]}, 32'd0);
    end
    chk("abort_ready", {31'b0, ready[2]}, 32'd1);
    op("abort_ld40", 2, 0, 2, 0, 32'h40, 32'h0, 32'h0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
